// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: two-port req/ack arbiter and strobe sequencer for a 16x8
// async SRAM with programmable write/read wait states (WAIT_WR, WAIT_RD).
// Build option SRAM_ARB_RR_EN: round-robin arbitration; fixed priority
// (port 0 first) when undefined.
// Ports: clk, rstb (async, active-low); per port req/we/addr/wdata in and
// ack out; rdata, busy; ram_addr, ram_data (inout), ram_ceb/web/oeb.
module sram_arb_ctrl #(
    parameter int unsigned WAIT_WR = 2,
    parameter int unsigned WAIT_RD = 2
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [3:0] addr0,
    input  logic [3:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [3:0] ram_addr,
    inout  wire  [7:0] ram_data,
    output logic       ram_ceb,
    output logic       ram_web,
    output logic       ram_oeb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WR,
        S_HOLD,
        S_RD
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic       gnt_q, gnt_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       oe_q, oe_d;
    logic       ceb_q, ceb_d;
    logic       web_q, web_d;
    logic       oeb_q, oeb_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       busy_q, busy_d;
    logic       sel;

`ifdef SRAM_ARB_RR_EN
    // Last granted port; reset to 1 so port 0 wins the first tie.
    logic last_q, last_d;

    always_comb begin
        sel = (req0 && req1) ? ~last_q : req1;
    end
`else
    always_comb begin
        sel = ~req0;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        oe_d    = oe_q;
        ceb_d   = ceb_q;
        web_d   = web_q;
        oeb_d   = oeb_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
`ifdef SRAM_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d = S_SETUP;
                    gnt_d   = sel;
                    we_d    = sel ? we1 : we0;
                    addr_d  = sel ? addr1 : addr0;
                    wdata_d = sel ? wdata1 : wdata0;
                    oe_d    = sel ? we1 : we0;
                    ceb_d   = 1'b0;
`ifdef SRAM_ARB_RR_EN
                    last_d  = sel;
`endif
                end
            end
            S_SETUP: begin
                if (we_q) begin
                    state_d = S_WR;
                    web_d   = 1'b0;
                    cnt_d   = 4'(WAIT_WR - 1);
                end else begin
                    state_d = S_RD;
                    oeb_d   = 1'b0;
                    cnt_d   = 4'(WAIT_RD - 1);
                end
            end
            S_WR: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                    web_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
                ceb_d   = 1'b1;
                oe_d    = 1'b0;
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
            end
            S_RD: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    rdata_d = ram_data;
                    oeb_d   = 1'b1;
                    ceb_d   = 1'b1;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            gnt_q   <= 1'b0;
            addr_q  <= 4'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            oe_q    <= 1'b0;
            ceb_q   <= 1'b1;
            web_q   <= 1'b1;
            oeb_q   <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            oe_q    <= oe_d;
            ceb_q   <= ceb_d;
            web_q   <= web_d;
            oeb_q   <= oeb_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
`ifdef SRAM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign ram_data = oe_q ? wdata_q : 8'hzz;
    assign ram_addr = addr_q;
    assign ram_ceb  = ceb_q;
    assign ram_web  = web_q;
    assign ram_oeb  = oeb_q;
    assign rdata    = rdata_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: two controllers (default waits, and WAIT_WR=5/WAIT_RD=1)
// each on its own SRAM model, driven by directed and random transactions.
module tb_sram_arb_ctrl;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstb;
    logic       req0[2], req1[2], we0[2], we1[2];
    logic [3:0] addr0[2], addr1[2];
    logic [7:0] wdata0[2], wdata1[2];
    logic       ack0[2], ack1[2], busy[2];
    logic       ceb[2], web[2], oeb[2];
    logic [7:0] rdata[2];
    logic [3:0] raddr[2];
    logic [7:0] bus_obs[2];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: expected memory, addresses of uncertain content,
    // and the last granted port seen by each arbiter.
    logic [7:0] ref_mem[2][16];
    bit         ref_unk[2][16];
    bit         rr_last[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wire  [7:0] bus;
        logic [7:0] mem [16] = '{default: 8'h00};

        sram_arb_ctrl #(
            .WAIT_WR(g == 0 ? 2 : 5),
            .WAIT_RD(g == 0 ? 2 : 1)
        ) u_dut (
            .clk     (clk),
            .rstb    (rstb),
            .req0    (req0[g]),
            .req1    (req1[g]),
            .we0     (we0[g]),
            .we1     (we1[g]),
            .addr0   (addr0[g]),
            .addr1   (addr1[g]),
            .wdata0  (wdata0[g]),
            .wdata1  (wdata1[g]),
            .ack0    (ack0[g]),
            .ack1    (ack1[g]),
            .rdata   (rdata[g]),
            .busy    (busy[g]),
            .ram_addr(raddr[g]),
            .ram_data(bus),
            .ram_ceb (ceb[g]),
            .ram_web (web[g]),
            .ram_oeb (oeb[g])
        );

        // Async SRAM read drive.
        assign bus = (ceb[g] === 1'b0 && oeb[g] === 1'b0 && web[g] === 1'b1)
                   ? mem[raddr[g]] : 8'hzz;
        // Bench drives 0x00 while the chip is deselected: any value other
        // than 0x00 there means the controller still drives the bus.
        assign bus = (ceb[g] === 1'b1) ? 8'h00 : 8'hzz;
        assign bus_obs[g] = bus;

        always @* begin
            if (ceb[g] === 1'b0 && web[g] === 1'b0 && !$isunknown(bus))
                mem[raddr[g]] = bus;
        end
    end

    function automatic int klat(int d, bit we);
        if (we) return (d == 0 ? 2 : 5) + 3;
        return (d == 0 ? 2 : 1) + 2;
    endfunction

    function automatic int lo_len(int d, bit we);
        if (we) return (d == 0 ? 2 : 5);
        return (d == 0 ? 2 : 1);
    endfunction

    // One transaction on port p; starts one step after a rising edge and
    // returns one step after the ack edge. keep leaves req high.
    task automatic run_txn(input int d, input bit p, input bit we,
                           input logic [3:0] a, input logic [7:0] wd,
                           input bit keep);
        int k, lo;
        bit got;
        logic [7:0] exp;
        if (p) begin
            req1[d] = 1'b1; we1[d] = we; addr1[d] = a; wdata1[d] = wd;
        end else begin
            req0[d] = 1'b1; we0[d] = we; addr0[d] = a; wdata0[d] = wd;
        end
        rr_last[d] = p;
        exp = ref_mem[d][a];
        k = 0; lo = 0; got = 1'b0;
        repeat (40) begin
            @(posedge clk); #1; k++;
            if ((p ? ack1[d] : ack0[d]) === 1'b1) begin
                got = 1'b1;
                break;
            end
            n_chk++;
            if (busy[d] !== 1'b1 || (p ? ack0[d] : ack1[d]) !== 1'b0 ||
                (oeb[d] === 1'b0 && web[d] === 1'b0)) begin
                n_fail++;
                $display("FAIL txn_cycle d%0d k=%0d busy=%b ack0=%b ack1=%b web=%b oeb=%b",
                         d, k, busy[d], ack0[d], ack1[d], web[d], oeb[d]);
            end
            if (we ? web[d] === 1'b0 : oeb[d] === 1'b0) lo++;
            if (k == 1) begin
                n_chk++;
                if (ceb[d] !== 1'b0 || raddr[d] !== a ||
                    (we && bus_obs[d] !== wd)) begin
                    n_fail++;
                    $display("FAIL setup d%0d ceb=%b addr=%h bus=%h want addr=%h data=%h",
                             d, ceb[d], raddr[d], bus_obs[d], a, wd);
                end
            end
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout d%0d port%0d got none want ack", d, p);
        end
        n_chk++;
        if (k != klat(d, we)) begin
            n_fail++;
            $display("FAIL latency d%0d we=%0d got %0d want %0d", d, we, k, klat(d, we));
        end
        n_chk++;
        if (lo != lo_len(d, we)) begin
            n_fail++;
            $display("FAIL strobe_len d%0d we=%0d got %0d want %0d", d, we, lo, lo_len(d, we));
        end
        n_chk++;
        if (busy[d] !== 1'b0 || ceb[d] !== 1'b1 || bus_obs[d] !== 8'h00 ||
            (p ? ack0[d] : ack1[d]) !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_cycle d%0d busy=%b ceb=%b bus=%h want 0,1,00",
                     d, busy[d], ceb[d], bus_obs[d]);
        end
        if (we) begin
            ref_mem[d][a] = wd;
            ref_unk[d][a] = 1'b0;
        end else if (ref_unk[d][a]) begin
            n_chk++;
            if (rdata[d] !== 8'h00 && rdata[d] !== 8'hFF) begin
                n_fail++;
                $display("FAIL rdata_unk d%0d a=%h got %h want 00 or FF", d, a, rdata[d]);
            end
            ref_mem[d][a] = rdata[d];
            ref_unk[d][a] = 1'b0;
        end else begin
            n_chk++;
            if (rdata[d] !== exp) begin
                n_fail++;
                $display("FAIL rdata d%0d a=%h got %h want %h", d, a, rdata[d], exp);
            end
        end
        if (!keep) begin
            if (p) req1[d] = 1'b0;
            else   req0[d] = 1'b0;
        end
    endtask

    task automatic test_reset;
        rstb = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req0[d] = 0; req1[d] = 0; we0[d] = 0; we1[d] = 0;
            addr0[d] = 0; addr1[d] = 0; wdata0[d] = 0; wdata1[d] = 0;
            rr_last[d] = 1'b1;
            for (int a = 0; a < 16; a++) begin
                ref_mem[d][a] = 8'h00;
                ref_unk[d][a] = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (ceb[d] !== 1'b1 || web[d] !== 1'b1 || oeb[d] !== 1'b1 ||
                raddr[d] !== 4'h0 || rdata[d] !== 8'h00 || ack0[d] !== 1'b0 ||
                ack1[d] !== 1'b0 || busy[d] !== 1'b0 || bus_obs[d] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_state d%0d ceb=%b web=%b oeb=%b addr=%h rdata=%h busy=%b bus=%h",
                         d, ceb[d], web[d], oeb[d], raddr[d], rdata[d], busy[d], bus_obs[d]);
            end
        end
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        run_txn(0, 1'b0, 1'b1, 4'd3, 8'hA5, 1'b0);
        run_txn(0, 1'b0, 1'b0, 4'd3, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid;
        bit seen;
        req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 4'd7; wdata0[0] = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (web[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wr_web got %b want 0", web[0]);
        end
        #2 rstb = 1'b0;
        #1;
        n_chk++;
        if (ceb[0] !== 1'b1 || web[0] !== 1'b1 || oeb[0] !== 1'b1 ||
            bus_obs[0] !== 8'h00 || ack0[0] !== 1'b0 || busy[0] !== 1'b0 ||
            rdata[0] !== 8'h00 || raddr[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset ceb=%b web=%b oeb=%b bus=%h busy=%b rdata=%h addr=%h",
                     ceb[0], web[0], oeb[0], bus_obs[0], busy[0], rdata[0], raddr[0]);
        end
        req0[0] = 1'b0;
        rr_last[0] = 1'b1;
        rr_last[1] = 1'b1;
        ref_unk[0][7] = 1'b1;
        @(negedge clk);
        rstb = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack0[0] !== 1'b0 || ack1[0] !== 1'b0 || busy[0] !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin
            n_fail++;
            $display("FAIL dropped_txn got ack/busy activity want none");
        end
        run_txn(0, 1'b0, 1'b0, 4'd7, 8'h00, 1'b0);
    endtask

    // Both ports request on the same edge; winner comes from the model.
    task automatic run_pair(input int d,
                            input bit w0, input logic [3:0] a0, input logic [7:0] d0,
                            input bit w1, input logic [3:0] a1, input logic [7:0] d1);
        bit first;
        int t0, t1, k, e0, e1;
        logic [7:0] r0, r1, x0, x1;
        first = RR ? ~rr_last[d] : 1'b0;
        if (first == 1'b0) begin
            x0 = ref_mem[d][a0];
            if (w0) ref_mem[d][a0] = d0;
            x1 = ref_mem[d][a1];
            if (w1) ref_mem[d][a1] = d1;
            e0 = klat(d, w0);
            e1 = e0 + klat(d, w1);
        end else begin
            x1 = ref_mem[d][a1];
            if (w1) ref_mem[d][a1] = d1;
            x0 = ref_mem[d][a0];
            if (w0) ref_mem[d][a0] = d0;
            e1 = klat(d, w1);
            e0 = e1 + klat(d, w0);
        end
        rr_last[d] = ~first;
        req0[d] = 1'b1; we0[d] = w0; addr0[d] = a0; wdata0[d] = d0;
        req1[d] = 1'b1; we1[d] = w1; addr1[d] = a1; wdata1[d] = d1;
        t0 = 0; t1 = 0; k = 0; r0 = 8'h00; r1 = 8'h00;
        repeat (60) begin
            @(posedge clk); #1; k++;
            if (ack0[d] === 1'b1) begin t0 = k; r0 = rdata[d]; req0[d] = 1'b0; end
            if (ack1[d] === 1'b1) begin t1 = k; r1 = rdata[d]; req1[d] = 1'b0; end
            if (t0 != 0 && t1 != 0) break;
        end
        n_chk++;
        if (t0 != e0 || t1 != e1) begin
            n_fail++;
            $display("FAIL arb_order d%0d ack0@%0d ack1@%0d want %0d,%0d", d, t0, t1, e0, e1);
        end
        n_chk++;
        if ((!w0 && r0 !== x0) || (!w1 && r1 !== x1)) begin
            n_fail++;
            $display("FAIL arb_rdata d%0d got %h,%h want %h,%h", d, r0, r1, x0, x1);
        end
        req0[d] = 1'b0;
        req1[d] = 1'b0;
    endtask

    task automatic test_arbitration;
        run_pair(0, 1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22);
        run_txn(0, 1'b0, 1'b0, 4'd1, 8'h00, 1'b0);
        run_txn(0, 1'b0, 1'b0, 4'd2, 8'h00, 1'b0);
        run_pair(0, 1'b1, 4'd8, 8'h81, 1'b1, 4'd9, 8'h92);
        run_txn(0, 1'b1, 1'b0, 4'd8, 8'h00, 1'b0);
        run_txn(0, 1'b1, 1'b0, 4'd9, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_txn(0, 1'b0, 1'b1, 4'd4, 8'h44, 1'b0);
        run_txn(0, 1'b0, 1'b1, 4'd5, 8'h55, 1'b0);
        run_txn(0, 1'b0, 1'b1, 4'd6, 8'h66, 1'b0);
        run_txn(0, 1'b1, 1'b0, 4'd4, 8'h00, 1'b1);
        run_txn(0, 1'b1, 1'b0, 4'd5, 8'h00, 1'b1);
        run_txn(0, 1'b1, 1'b0, 4'd6, 8'h00, 1'b0);
    endtask

    task automatic test_wait_states;
        run_txn(1, 1'b0, 1'b1, 4'd15, 8'h3C, 1'b0);
        run_txn(1, 1'b0, 1'b0, 4'd15, 8'h00, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            int d;
            d = i % 2;
            if ((i % 8) == 7) begin
                run_pair(d, 1'($urandom), 4'($urandom_range(8, 15)), 8'($urandom),
                            1'($urandom), 4'($urandom_range(8, 15)), 8'($urandom));
            end else begin
                run_txn(d, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 1'b0);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_arbitration();
        test_back_to_back();
        test_wait_states();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arb_ctrl.md
# sram_arb_ctrl

Synchronous controller and two-port arbiter for the 16 x 8 asynchronous SRAM (active-low `ceb`/`web`/`oeb`, bidirectional data bus). Two clocked requesters each issue single-word read or write requests through a req/ack handshake. The block arbitrates between them and sequences the SRAM strobes with programmable wait states. It drives or releases the shared data bus and returns read data in a register.

## Interface
- `WAIT_WR`, 2: cycles `ram_web` is held low per write; legal range 1..15.
- `WAIT_RD`, 2: cycles `ram_oeb` is held low before read data is captured; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rstb`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1  request; held high until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req is high.
- `addr0`, `addr1`  in  4  word address; stable while req is high.
- `wdata0`, `wdata1`  in  8  write data; stable while req is high.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  8  read data; valid in the ack cycle, held until the next read.
- `busy`  out  1  high in every state except IDLE.
- `ram_addr`  out  4  SRAM address.
- `ram_data`  inout  8  SRAM data bus; driven only during writes, hi-Z otherwise.
- `ram_ceb`, `ram_web`, `ram_oeb`  out  1  SRAM strobes, active-low.

## Operation
- All outputs are registered. The tri-state enable and the write-data register are registered.
- Reset values:
  - `ram_ceb`, `ram_web`, `ram_oeb` = 1.
  - `ram_addr` = 0, `rdata` = 0.
  - `ack0`, `ack1`, `busy` = 0.
  - `ram_data` is hi-Z.
  - Arbiter state is cleared.
- State machine: IDLE, SETUP, WR, HOLD, RD.
  - IDLE:
    - Samples `req0`/`req1` only when both acks are low.
    - On a grant, latches the granted port's we/addr/wdata and goes to SETUP.
  - SETUP (1 cycle):
    - `ram_ceb` = 0, `ram_addr` driven, `ram_web` = `ram_oeb` = 1.
    - For a write, `ram_data` is driven from SETUP onward.
    - Goes to WR or RD.
  - WR:
    - `ram_web` = 0 for exactly WAIT_WR cycles, then HOLD.
  - HOLD (1 cycle):
    - `ram_web` = 1; `ram_ceb` stays 0; data stays driven.
    - Goes to IDLE, asserting the granted ack.
  - RD:
    - `ram_oeb` = 0 for WAIT_RD cycles.
    - On the last edge, `ram_data` is captured into `rdata`, `ram_oeb` = `ram_ceb` = 1, the granted ack is asserted, and the FSM goes to IDLE.
- Entering IDLE: `ram_ceb` = 1 and the data bus is released.
- The ack cycle is a dead cycle. No request is sampled during it, and the bus is not driven, so there is never bus contention between a read and the following write.
- Wait counter: 4-bit down-counter, loaded with WAIT_x − 1 on entry to WR/RD. The state exits when the counter reaches 0.
- Arbitration: fixed priority, port 0 over port 1 (see Configuration). A request that loses arbitration stays pending and is served next.
- A `req` still high in the cycle after its ack is treated as a new request.
- Reset mid-operation: all strobes return to 1 and the bus is released asynchronously. The transaction is dropped with no ack, and `rdata` is cleared.

## Timing
- Sampling edge N (IDLE, acks low, req high) to SETUP.
- Write:
  - `ram_web` is low from edge N+1 to edge N+1+WAIT_WR.
  - Ack is high from edge N+2+WAIT_WR for one cycle.
  - Default WAIT_WR = 2: ack at N+4.
- Read:
  - `ram_oeb` is low from edge N+1; `rdata` is captured at edge N+1+WAIT_RD.
  - Ack is high for one cycle from that same edge.
  - Default WAIT_RD = 2: ack at N+3.
- Back-to-back requests: the next sampling edge is the edge ending the ack cycle.
  - Write throughput: one write per WAIT_WR+3 cycles.
  - Read throughput: one read per WAIT_RD+2 cycles.
- The bench clock period must exceed the SRAM access time (1.5 ns read, 1 ns write). The bench uses a 10 ns clock.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer records the last granted port.
  - On simultaneous requests, the other port wins.
  - Pointer reset value favours port 0.
- `SRAM_ARB_RR_EN` undefined: fixed priority; port 0 always wins ties.
- The port list is identical in both builds.

## Test plan
- Port 0 write 0xA5 to addr 3, then port 0 read of addr 3 (defaults):
  - Write ack0 at N+4; `ram_web` is low for exactly 2 cycles.
  - Read ack0 at N+3 with `rdata` = 0xA5.
  - `ack1` never pulses.
- `req0` and `req1` raised on the same edge, both writes (addr 1 = 0x11, addr 2 = 0x22):
  - Port 0 is served first, then port 1.
  - Read-back gives 0x11 and 0x22.
  - With `SRAM_ARB_RR_EN`, a second simultaneous pair is served port 1 first.
- `req1` held high for 3 consecutive reads of addrs 4, 5, 6:
  - Acks are spaced WAIT_RD+2 = 4 cycles apart.
  - Exactly one bus-hi-Z ack cycle separates each access.
  - `busy` is low only in the ack cycles.
- `rstb` pulsed low during WR of 0xFF to addr 7, whose prior content is 0x00:
  - Strobes go to 1 and `ram_data` goes hi-Z immediately.
  - No ack is produced.
  - A later read of addr 7 returns 0x00 or 0xFF, never X.
  - All outputs hold their reset values.
- WAIT_WR = 5, WAIT_RD = 1, write then read 0x3C at addr 15:
  - `ram_web` is low for 5 cycles; write ack at N+7.
  - Read ack at N+2 with `rdata` = 0x3C.
- Contention check: throughout all scenarios, `ram_data` is never driven by the controller while `ram_oeb` = 0.
